// File: rtl/trng_health_fifo.sv
// rtl/trng_health_fifo.sv - TRNG byte intake with repetition-count and adaptive-proportion
// health tests feeding a first-word-fall-through FIFO; any trip flushes and latches an alarm.
module trng_health_fifo #(
   parameter int DEPTH      = 8,
   parameter int RCT_CUTOFF = 4,
   parameter int APT_WINDOW = 64,
   parameter int APT_CUTOFF = 8,
   parameter int STARTUP    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 trng_data,
   input  logic                       trng_ready,
   output logic                       trng_consume,
   input  logic                       pop,
   output logic [7:0]                 dout,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       fail,
   output logic [1:0]                 fail_src,
   input  logic                       clear_fail
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam int PW = $clog2(APT_CUTOFF + 1);
   localparam int WW = $clog2(APT_WINDOW);
   localparam int SW = $clog2(STARTUP + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
   localparam logic [PW-1:0] APT_MAX  = PW'(APT_CUTOFF);
   localparam logic [SW-1:0] SU_INIT  = SW'(STARTUP);

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          fail_q, fail_d;
   logic [1:0]    fail_src_q, fail_src_d;
   logic [7:0]    last_q, last_d, apt_ref_q, apt_ref_d;
   logic [RW-1:0] rct_cnt_q, rct_cnt_d, rct_new;
   logic          rct_vld_q, rct_vld_d;
   logic [PW-1:0] apt_cnt_q, apt_cnt_d, apt_new;
   logic [WW-1:0] win_idx_q, win_idx_d;
   logic [SW-1:0] startup_q, startup_d;
   logic          accept, rct_trip, apt_trip, trip, push, do_pop;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      fail_d     = fail_q;
      fail_src_d = fail_src_q;
      last_d     = last_q;
      apt_ref_d  = apt_ref_q;
      rct_cnt_d  = rct_cnt_q;
      rct_vld_d  = rct_vld_q;
      apt_cnt_d  = apt_cnt_q;
      win_idx_d  = win_idx_q;
      startup_d  = startup_q;

      accept = rst_n & trng_ready & ~fail_q & (level_q != FULL_LVL) & ~clear_fail;

      if (rct_vld_q && trng_data == last_q)
         rct_new = (rct_cnt_q == RCT_MAX) ? RCT_MAX : rct_cnt_q + RW'(1);
      else
         rct_new = RW'(1);
      if (win_idx_q == '0)
         apt_new = PW'(1);
      else if (trng_data == apt_ref_q && apt_cnt_q != APT_MAX)
         apt_new = apt_cnt_q + PW'(1);
      else
         apt_new = apt_cnt_q;

      rct_trip = accept & (rct_new == RCT_MAX);
      apt_trip = accept & (apt_new == APT_MAX);
      trip     = rct_trip | apt_trip;
      push     = accept & ~trip & (startup_q == '0);
      do_pop   = pop & (level_q != '0) & ~trip;

      if (accept) begin
         last_d    = trng_data;
         rct_cnt_d = rct_new;
         rct_vld_d = 1'b1;
         apt_cnt_d = apt_new;
         win_idx_d = win_idx_q + WW'(1);
         if (win_idx_q == '0) apt_ref_d = trng_data;
         if (startup_q != '0) startup_d = startup_q - SW'(1);
      end

      if (push) begin
         mem_d[wr_ptr_q] = trng_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !do_pop)      level_d = level_q + LW'(1);
      else if (!push && do_pop) level_d = level_q - LW'(1);

      // A trip discards the tripping byte and everything already buffered.
      if (trip) begin
         fail_d     = 1'b1;
         fail_src_d = {apt_trip, rct_trip};
         level_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end

      if (clear_fail) begin
         fail_d     = 1'b0;
         fail_src_d = 2'b00;
         rct_cnt_d  = '0;
         rct_vld_d  = 1'b0;
         apt_cnt_d  = '0;
         win_idx_d  = '0;
         startup_d  = SU_INIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         fail_q     <= 1'b0;
         fail_src_q <= 2'b00;
         last_q     <= 8'h00;
         apt_ref_q  <= 8'h00;
         rct_cnt_q  <= '0;
         rct_vld_q  <= 1'b0;
         apt_cnt_q  <= '0;
         win_idx_q  <= '0;
         startup_q  <= SU_INIT;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         fail_q     <= fail_d;
         fail_src_q <= fail_src_d;
         last_q     <= last_d;
         apt_ref_q  <= apt_ref_d;
         rct_cnt_q  <= rct_cnt_d;
         rct_vld_q  <= rct_vld_d;
         apt_cnt_q  <= apt_cnt_d;
         win_idx_q  <= win_idx_d;
         startup_q  <= startup_d;
      end
   end

   assign trng_consume = accept;
   assign valid        = (level_q != '0);
   assign dout         = valid ? mem_q[rd_ptr_q] : 8'h00;
   assign level        = level_q;
   assign fail         = fail_q;
   assign fail_src     = fail_src_q;
endmodule

// File: tb/tb_trng_health_fifo.sv
// tb/tb_trng_health_fifo.sv - scoreboard bench: stimulus queues hand-computed bytes,
// a monitor compares each popped FIFO head against the queue.
module tb_trng_health_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] trng_data = 8'h00;
   logic       trng_ready = 1'b0;
   logic       trng_consume;
   logic       pop = 1'b0;
   logic [7:0] dout;
   logic       valid;
   logic [3:0] level;
   logic       fail;
   logic [1:0] fail_src;
   logic       clear_fail = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb[$];

   trng_health_fifo dut (
      .clk(clk), .rst_n(rst_n), .trng_data(trng_data), .trng_ready(trng_ready),
      .trng_consume(trng_consume), .pop(pop), .dout(dout), .valid(valid),
      .level(level), .fail(fail), .fail_src(fail_src), .clear_fail(clear_fail)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle the host pops a valid head, it must match the oldest expected byte.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && pop && valid) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected actual=0x%0h required=none", dout);
            end else begin
               if (dout !== sb[0]) begin
                  failures++;
                  $display("FAIL pop_data actual=0x%0h required=0x%0h", dout, sb[0]);
               end
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic exp_push);
      int n = 0;
      @(negedge clk);
      trng_data  = b;
      trng_ready = 1'b1;
      #1;
      while (!trng_consume && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!trng_consume) begin
         checks++;
         failures++;
         $display("FAIL consume_timeout actual=0 required=1 byte=0x%0h", b);
         trng_ready = 1'b0;
      end else begin
         if (exp_push) sb.push_back(b);
         @(posedge clk);
         #1 trng_ready = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear_fail = 1'b1;
      trng_ready = 1'b1;
      trng_data  = 8'h77;
      #1 check("consume_in_clear", trng_consume, 0);
      @(posedge clk);
      #1;
      clear_fail = 1'b0;
      trng_ready = 1'b0;
      @(negedge clk);
      #1;
      check("fail_cleared", fail, 0);
      check("fail_src_cleared", fail_src, 0);
   endtask

   initial begin
      logic [7:0] b;
      trng_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_consume", trng_consume, 0);
      check("rst_valid", valid, 0);
      check("rst_level", level, 0);
      check("rst_dout", dout, 0);
      check("rst_fail", fail, 0);
      check("rst_fail_src", fail_src, 0);
      @(negedge clk);
      rst_n = 1'b1;
      trng_ready = 1'b0;

      // Startup discard: 0x01..0x10 dropped, 0x11..0x18 fill the FIFO.
      for (int i = 1; i <= 24; i++) begin
         b = 8'(i);
         send(b, i > 16);
      end
      @(negedge clk);
      trng_ready = 1'b1;
      trng_data  = 8'h19;
      #1;
      check("full_level", level, 8);
      check("full_consume", trng_consume, 0);
      check("full_head", dout, 8'h11);

      // Drain while streaming 0x19..0x20: push and pop together hold level at 7.
      pop = 1'b1;
      for (int i = 8'h19; i <= 8'h20; i++) begin
         b = 8'(i);
         send(b, 1'b1);
         check("stream_level", level, 7);
      end
      repeat (10) @(negedge clk);
      pop = 1'b0;
      #1;
      check("drain_level", level, 0);
      check("drain_valid", valid, 0);
      check("drain_dout", dout, 0);
      check("drain_sb_empty", sb.size(), 0);

      // RCT: fourth consecutive 0xA5 trips and flushes the three buffered copies.
      repeat (3) send(8'hA5, 1'b1);
      @(negedge clk);
      #1 check("rct_pre_level", level, 3);
      send(8'hA5, 1'b0);
      sb.delete();
      check("rct_fail", fail, 1);
      check("rct_src", fail_src, 2'b01);
      check("rct_level", level, 0);
      check("rct_valid", valid, 0);
      @(negedge clk);
      trng_ready = 1'b1;
      trng_data  = 8'h33;
      #1 check("rct_consume_held", trng_consume, 0);

      // APT: window A has 7 matches to 0x3C and passes; window B trips on its 8th match.
      do_clear();
      pop = 1'b1;
      for (int i = 0; i < 64; i++) begin
         b = (i % 2 == 0 && i < 14) ? 8'h3C : 8'(8'h80 + i);
         send(b, i >= 16);
      end
      check("apt_window_pass", fail, 0);
      for (int i = 0; i < 15; i++) begin
         b = (i % 2 == 0) ? 8'h3C : 8'(8'h40 + i);
         send(b, i < 14);
      end
      sb.delete();
      pop = 1'b0;
      check("apt_fail", fail, 1);
      check("apt_src", fail_src, 2'b10);
      check("apt_level", level, 0);

      // Recovery: 16 bytes discarded after clear, the 17th is the FIFO head.
      do_clear();
      for (int i = 0; i < 16; i++) begin
         b = 8'(8'h60 + i);
         send(b, 1'b0);
      end
      check("recover_startup_level", level, 0);
      send(8'h50, 1'b1);
      check("recover_valid", valid, 1);
      check("recover_head", dout, 8'h50);
      for (int i = 1; i <= 4; i++) begin
         b = 8'(8'h50 + i);
         send(b, 1'b1);
      end
      @(negedge clk);
      #1 check("midfill_level", level, 5);

      // Asynchronous reset mid-fill.
      #1;
      rst_n = 1'b0;
      trng_ready = 1'b1;
      #1;
      check("arst_level", level, 0);
      check("arst_valid", valid, 0);
      check("arst_dout", dout, 0);
      check("arst_consume", trng_consume, 0);
      check("arst_fail", fail, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      trng_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b = 8'(8'h90 + i);
         send(b, 1'b0);
      end
      check("arst_startup_level", level, 0);
      send(8'hAA, 1'b1);
      check("arst_after_head", dout, 8'hAA);
      check("arst_after_level", level, 1);
      pop = 1'b1;
      repeat (3) @(negedge clk);
      pop = 1'b0;
      #3;
      check("final_sb_empty", sb.size(), 0);
      check("final_level", level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
